pseudo_spi_sram_loader: RTL
===========================

// Module: pseudo_spi_sram_loader
// PURPOSE
//   Receive side of the pseudo-SPI link: accepts LSB-first serial bytes on SPI_SI,
//   framed by SEL and clocked by two-phase SCLK1/SCLK2, and writes them into the
//   512x8 SRAM from ADDR_BGN for DATA_LEN bytes. Shares the SRAM port through the
//   top-level mux, same as the readout path. CLK oversamples all serial inputs.
// PARAMETERS
//   MEMORY_DATA_WIDTH  8  bits per SRAM word / serial byte
//   MEMORY_ADDR_WIDTH  9  SRAM address width
//   RESERVED_DATA_LEN  8  width of DATA_LEN byte counter
//   SYNC_STAGES        2  synchroniser depth on SCLK1/SCLK2/SEL/SPI_SI (>=2)
// PORTS
//   CLK       in   1    system clock
//   rst_n     in   1    synchronous active-low reset
//   BGN       in   1    level enable; high = run transfer, low = return to idle
//   ADDR_BGN  in   AW   first SRAM address, latched on start
//   DATA_LEN  in   LW   byte count, latched on start
//   SCLK1     in   1    serial phase-1 clock (async); rising edge samples SPI_SI
//   SCLK2     in   1    serial phase-2 clock (async); must never overlap SCLK1
//   SEL       in   1    frame select, high while a byte is being shifted
//   SPI_SI    in   1    serial data, LSB first
//   CEN       out  1    SRAM chip enable, active low
//   D_WE      out  1    SRAM write strobe, 1 = write
//   A         out  AW   SRAM address
//   PO        out  DW   SRAM write data
//   RDY       out  1    transfer complete, held until BGN low
//   ERR       out  1    sticky protocol error; cleared only on IDLE->start
// BEHAVIOUR
// - Reset (rst_n=0 at CLK rise): state IDLE, CEN=1, D_WE=0, A=0, PO=0, RDY=0, ERR=0,
//   shift reg, bit count, pending flag, sync chains all 0. Mid-write reset cancels write.
// - Inputs pass SYNC_STAGES flops; rise1 = s_SCLK1 & ~s_SCLK1_d. Pin-to-sample
//   latency SYNC_STAGES+1 CLK. Master holds SCLK1 high/low >= SYNC_STAGES+2 CLK each.
// - States: IDLE, SHIFT, WRITE, NEXT, DONE.
// - IDLE: CEN=1, D_WE=0, RDY=0. BGN=1 -> addr<=ADDR_BGN, rem<=DATA_LEN, ERR<=0,
//   bitcnt<=0; rem==0 -> DONE, else SHIFT.
// - SHIFT: rise1 with s_SEL=1 and s_SCLK2=0 -> sreg<={s_SI,sreg[DW-1:1]}, bitcnt+1;
//   on DW-th bit -> WRITE next cycle, bitcnt<=0. rise1 with s_SEL=0 ignored.
//   s_SEL falls with 0<bitcnt<DW -> partial byte dropped, bitcnt<=0, ERR<=1, stay SHIFT.
//   s_SCLK1 & s_SCLK2 both 1 -> ERR<=1, that edge not sampled.
// - WRITE (1 cycle): CEN=0, D_WE=1, A=addr, PO=sreg. Only cycle CEN=0.
// - NEXT (1 cycle): CEN=1, D_WE=0; addr<=addr+1 mod 2^AW; rem<=rem-1;
//   rem==1 -> DONE else SHIFT.
// - rise1 in WRITE/NEXT sets one-bit pending flag; SHIFT consumes it first cycle.
// - Write latency: CEN low exactly 1 CLK after SHIFT sees DW-th rise1.
// - DONE: RDY=1, CEN=1, D_WE=0; BGN=0 -> IDLE next cycle, RDY=0.
// - BGN=0 in SHIFT -> IDLE, no write, partial byte dropped. BGN=0 in WRITE -> write
//   completes, then IDLE (NEXT skipped, RDY stays 0).
// - Outputs registered; A/PO hold last values outside WRITE.
// TESTING
// - ADDR_BGN=0x020, DATA_LEN=3, bytes AB,3C,05 -> three single-cycle CEN=0/D_WE=1
//   pulses, SRAM[020..022]=AB,3C,05, RDY=1 after 3rd, ERR=0; readback via SRAM
//   readout path matches.
// - DATA_LEN=0, BGN=1 -> DONE/RDY=1 on 2nd CLK, no CEN pulse; BGN=0 -> RDY=0 next cycle.
// - ADDR_BGN=0x1FF, DATA_LEN=2, bytes 9E,3D -> SRAM[1FF]=9E, SRAM[000]=3D.
// - SEL dropped after 5 bits, then full byte D7 -> ERR=1, one write only,
//   A=ADDR_BGN, PO=D7.
// - SCLK1/SCLK2 overlapped on one bit -> ERR=1, bit skipped; 8 more clean edges
//   complete the byte.
// - rst_n=0 mid byte 2 of 3 -> all outputs reset next CLK, no further writes;
//   separate run with BGN=0 mid-byte -> IDLE, no write, RDY=0.

Source files
------------

// File: rtl/pseudo_spi_sram_loader_if.sv
// Bus bundle between the pseudo-SPI loader and its environment: transfer
// control (BGN/ADDR_BGN/DATA_LEN), the raw serial pins, and the SRAM write port
// with its RDY/ERR status.
//   master : drives control and serial pins, observes SRAM port and status
//   slave  : the loader itself
interface pseudo_spi_sram_loader_if #(
  parameter int unsigned MEMORY_DATA_WIDTH = 8,
  parameter int unsigned MEMORY_ADDR_WIDTH = 9,
  parameter int unsigned RESERVED_DATA_LEN = 8
) ();
  logic                         BGN;
  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN;
  logic [RESERVED_DATA_LEN-1:0] DATA_LEN;
  logic                         SCLK1;
  logic                         SCLK2;
  logic                         SEL;
  logic                         SPI_SI;
  logic                         CEN;
  logic                         D_WE;
  logic [MEMORY_ADDR_WIDTH-1:0] A;
  logic [MEMORY_DATA_WIDTH-1:0] PO;
  logic                         RDY;
  logic                         ERR;

  modport master (
    output BGN, ADDR_BGN, DATA_LEN, SCLK1, SCLK2, SEL, SPI_SI,
    input  CEN, D_WE, A, PO, RDY, ERR
  );

  modport slave (
    input  BGN, ADDR_BGN, DATA_LEN, SCLK1, SCLK2, SEL, SPI_SI,
    output CEN, D_WE, A, PO, RDY, ERR
  );
endinterface

// File: rtl/pseudo_spi_sram_loader.sv
// Receive side of the pseudo-SPI link. Oversamples SCLK1/SCLK2/SEL/SPI_SI on
// CLK, assembles LSB-first bytes on SCLK1 rising edges inside a SEL frame and
// writes each completed byte to consecutive SRAM addresses starting at ADDR_BGN
// until DATA_LEN bytes are stored.
// Ports:
//   CLK    system clock
//   rst_n  synchronous active-low reset
//   bus    slave modport: BGN, ADDR_BGN, DATA_LEN, SCLK1, SCLK2, SEL, SPI_SI in;
//          CEN, D_WE, A, PO, RDY, ERR out (all registered)
module pseudo_spi_sram_loader #(
  parameter int unsigned MEMORY_DATA_WIDTH = 8,
  parameter int unsigned MEMORY_ADDR_WIDTH = 9,
  parameter int unsigned RESERVED_DATA_LEN = 8,
  parameter int unsigned SYNC_STAGES       = 2
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  pseudo_spi_sram_loader_if.slave  bus
);

  localparam int unsigned DW = MEMORY_DATA_WIDTH;
  localparam int unsigned AW = MEMORY_ADDR_WIDTH;
  localparam int unsigned LW = RESERVED_DATA_LEN;
  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WRITE,
    ST_NEXT,
    ST_DONE
  } state_t;

  // Synchroniser chain, one 4-bit slice per stage: {SPI_SI, SEL, SCLK2, SCLK1}
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic                        s_sclk1, s_sclk2, s_sel, s_si;
  logic                        sclk1_prev_q, sel_prev_q;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [LW-1:0]   rem_q, rem_d;
  logic [CW-1:0]   bitcnt_q, bitcnt_d;
  logic [DW-1:0]   sreg_q, sreg_d;
  logic            pend_q, pend_d;
  logic            err_q, err_d;

  logic            cen_q, we_q, rdy_q;
  logic [AW-1:0]   a_q;
  logic [DW-1:0]   po_q;

  logic            rise1, sel_fall, valid_rise, overlap, wr_d;

  assign s_sclk1 = sync_q[SYNC_STAGES-1][0];
  assign s_sclk2 = sync_q[SYNC_STAGES-1][1];
  assign s_sel   = sync_q[SYNC_STAGES-1][2];
  assign s_si    = sync_q[SYNC_STAGES-1][3];

  assign rise1      = s_sclk1 & ~sclk1_prev_q;
  assign sel_fall   = sel_prev_q & ~s_sel;
  // An SCLK1 edge only counts inside a frame and with the phase clocks apart
  assign valid_rise = rise1 & s_sel & ~s_sclk2;
  assign overlap    = s_sclk1 & s_sclk2;

  // State, datapath and registered outputs
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      sync_q       <= '0;
      sclk1_prev_q <= 1'b0;
      sel_prev_q   <= 1'b0;
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      bitcnt_q     <= '0;
      sreg_q       <= '0;
      pend_q       <= 1'b0;
      err_q        <= 1'b0;
      cen_q        <= 1'b1;
      we_q         <= 1'b0;
      a_q          <= '0;
      po_q         <= '0;
      rdy_q        <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], {bus.SPI_SI, bus.SEL, bus.SCLK2, bus.SCLK1}};
      sclk1_prev_q <= s_sclk1;
      sel_prev_q   <= s_sel;
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      bitcnt_q     <= bitcnt_d;
      sreg_q       <= sreg_d;
      pend_q       <= pend_d;
      err_q        <= err_d;
      // Outputs follow the state being entered so they line up with it
      cen_q        <= ~wr_d;
      we_q         <= wr_d;
      rdy_q        <= (state_d == ST_DONE);
      if (wr_d) begin
        a_q  <= addr_q;
        po_q <= sreg_d;
      end
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    bitcnt_d = bitcnt_q;
    sreg_d   = sreg_q;
    pend_d   = pend_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        pend_d = 1'b0;
        if (bus.BGN) begin
          addr_d   = bus.ADDR_BGN;
          rem_d    = bus.DATA_LEN;
          err_d    = 1'b0;
          bitcnt_d = '0;
          state_d  = (bus.DATA_LEN == '0) ? ST_DONE : ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        pend_d = 1'b0;
        if (!bus.BGN) begin
          bitcnt_d = '0;
          state_d  = ST_IDLE;
        end else begin
          if (overlap) err_d = 1'b1;
          // Frame closed mid-byte: discard the partial byte
          if (sel_fall && (bitcnt_q != '0)) begin
            bitcnt_d = '0;
            err_d    = 1'b1;
          end else if (valid_rise || pend_q) begin
            sreg_d = {s_si, sreg_q[DW-1:1]};
            if (bitcnt_q == CW'(DW - 1)) begin
              bitcnt_d = '0;
              state_d  = ST_WRITE;
            end else begin
              bitcnt_d = bitcnt_q + CW'(1);
            end
          end
        end
      end

      ST_WRITE: begin
        if (valid_rise) pend_d = 1'b1;
        state_d = bus.BGN ? ST_NEXT : ST_IDLE;
      end

      ST_NEXT: begin
        if (valid_rise) pend_d = 1'b1;
        addr_d = addr_q + AW'(1);
        rem_d  = rem_q - LW'(1);
        if (!bus.BGN)                state_d = ST_IDLE;
        else if (rem_q == LW'(1))    state_d = ST_DONE;
        else                         state_d = ST_SHIFT;
      end

      ST_DONE: begin
        if (!bus.BGN) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_d = (state_d == ST_WRITE);

  assign bus.CEN  = cen_q;
  assign bus.D_WE = we_q;
  assign bus.A    = a_q;
  assign bus.PO   = po_q;
  assign bus.RDY  = rdy_q;
  assign bus.ERR  = err_q;

endmodule
